// File: rtl/mips_cpu_muldiv_pkg.sv
// rtl/mips_cpu_muldiv_pkg.sv - shared op codes and FSM states for the mul/div unit
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mips_cpu_divider_iter.sv
// rtl/mips_cpu_divider_iter.sv - restoring divider on magnitudes, one quotient bit per step
module mips_cpu_divider_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo, rem, dvs, diff;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // quo doubles as the dividend shift register; freed low bits receive quotient bits
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs};
    assign diff    = shifted[WIDTH-1:0] - dvs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            rem <= ge ? diff : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - iterative MIPS HI/LO multiply/divide unit
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic               op_div, neg_a, neg_b, b_zero;
    logic [WIDTH-1:0]   a_r, mcand, quo, rem;
    logic [2*WIDTH-1:0] prod, prod_fixed;
    logic [WIDTH:0]     psum;
    logic               is_calc_op, is_signed_op, start_calc;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        is_calc_op   = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        is_signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_mag        = (is_signed_op && a[WIDTH-1]) ? -a : a;
        b_mag        = (is_signed_op && b[WIDTH-1]) ? -b : b;
        start_calc   = (state == ST_IDLE) && start && is_calc_op;
    end

    // Multiplier bits sit in the low half of prod and are consumed as the accumulator shifts in
    assign psum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_fixed = (neg_a ^ neg_b) ? -prod : prod;

    mips_cpu_divider_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (start_calc),
        .step      ((state == ST_CALC) && op_div),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            a_r    <= '0;
            mcand  <= '0;
            prod   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_calc) begin
                        state  <= ST_CALC;
                        cnt    <= '0;
                        op_div <= (op == MD_DIV) || (op == MD_DIVU);
                        neg_a  <= is_signed_op && a[WIDTH-1];
                        neg_b  <= is_signed_op && b[WIDTH-1];
                        b_zero <= (b == '0);
                        a_r    <= a;
                        mcand  <= a_mag;
                        prod   <= {{WIDTH{1'b0}}, b_mag};
                    end else if (start && op == MD_MTHI) begin
                        hi   <= a;
                        done <= 1'b1;
                    end else if (start && op == MD_MTLO) begin
                        lo   <= a;
                        done <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (!op_div) begin
                        prod <= {psum, prod[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    if (!op_div) begin
                        {hi, lo} <= prod_fixed;
                    end else if (b_zero) begin
                        hi <= a_r;
                        lo <= '1;
                    end else begin
                        lo <= (neg_a ^ neg_b) ? -quo : quo;
                        hi <= neg_a ? -rem : rem;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb/tb_mips_cpu_muldiv.sv - self-checking bench for mips_cpu_muldiv
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain integer arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'd0: {m_hi, m_lo} = sx * sy;
            3'd1: begin up = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = up; end
            3'd2: if (y == 0) begin m_hi = x; m_lo = '1; end
                  else begin sq = sx / sy; sr = sx % sy; m_lo = sq[31:0]; m_hi = sr[31:0]; end
            3'd3: if (y == 0) begin m_hi = x; m_lo = '1; end
                  else begin m_lo = x / y; m_hi = x % y; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        logic mt;
        mt = (o == 3'd4) || (o == 3'd5);
        model(o, x, y);
        issue(o, x, y);
        chk({tag, ".busy"}, {63'b0, busy}, {63'b0, !mt});
        wait_done(lat);
        chk({tag, ".lat"}, 64'(lat), mt ? 64'd0 : 64'd33);
        chk({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int lat;
        logic saw;
        logic [31:0] x, y;
        logic [2:0] o;

        #12;
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.flags", {62'b0, busy, done}, 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max.const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op("mult_neg", 3'd0, 32'hFFFFFFF9, 32'd3);
        chk("mult_neg.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_neg.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu", 3'd3, 32'd100, 32'd7);
        chk("divu.const", {hi, lo}, {32'd2, 32'd14});
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf.const", {hi, lo}, 64'h00000000_80000000);
        run_op("divu_zero", 3'd3, 32'd5, 32'd0);
        chk("divu_zero.const", {hi, lo}, {32'd5, 32'hFFFFFFFF});
        run_op("div_zero", 3'd2, 32'hFFFFFF00, 32'd0);

        run_op("mthi", 3'd4, 32'h1234, 32'd0);
        chk("mthi.const", {32'b0, hi}, 64'h1234);
        run_op("mtlo", 3'd5, 32'hCAFE, 32'd0);
        @(posedge clk); #1;
        chk("done.width", {63'b0, done}, 64'd0);

        model(3'd6, 32'd1, 32'd1);
        issue(3'd6, 32'hDEAD, 32'd1);
        chk("undef.flags", {62'b0, busy, done}, 64'd0);
        @(posedge clk); #1;
        chk("undef.hilo", {62'b0, busy, done}, 64'd0);
        chk("undef.regs", {hi, lo}, {m_hi, m_lo});

        // Second start during CALC must be dropped
        model(3'd1, 32'd3, 32'd5);
        issue(3'd1, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        issue(3'd3, 32'd100, 32'd7);
        wait_done(lat);
        chk("busy_start.lat", 64'(lat), 64'd27);
        chk("busy_start.hilo", {hi, lo}, {m_hi, m_lo});
        @(posedge clk); #1;
        chk("busy_start.idle", {62'b0, busy, done}, 64'd0);

        // Reset in the middle of a multiply
        issue(3'd1, 32'hFFFF1234, 32'h89ABCDEF);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst.hilo", {hi, lo}, 64'd0);
        chk("midrst.flags", {62'b0, busy, done}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        chk("midrst.quiet", {63'b0, saw}, 64'd0);
        chk("midrst.regs", {hi, lo}, 64'd0);
        run_op("post_rst_divu", 3'd3, 32'd9, 32'd4);
        chk("post_rst_divu.const", {hi, lo}, {32'd1, 32'd2});

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 7) == 0) x = 32'h80000000;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 20));
            run_op($sformatf("rand%0d_op%0d", i, o), o, x, y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
